mood_fade_sequencer: RTL and testbench

MOOD_FADE_SEQUENCER -- requirements
Module: mood_fade_sequencer

---
 rtl/mood_fade_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mood_fade_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mood_fade_sequencer.sv
// Mood-light colour sequencer: manual RGB level control or automatic fade/hold cycling.
// Optional `MOOD_SKIP_EN: pb_up during FADE_UP/HOLD jumps straight to FADE_DOWN.
module mood_fade_sequencer #(
  parameter int unsigned TICK_DIV   = 5000000,
  parameter int unsigned HOLD_TICKS = 10
) (
  input  logic       main_Clk50Mhz,
  input  logic       main_rst,
  input  logic       mode_auto,
  input  logic       pb_up,
  input  logic       pb_down,
  input  logic [2:0] sw_rgb,
  output logic [2:0] sel_r,
  output logic [2:0] sel_g,
  output logic [2:0] sel_b,
  output logic [2:0] step_idx
);

  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned HOLD_LAST = (HOLD_TICKS > 1) ? HOLD_TICKS - 1 : 0;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_LAST);

  typedef enum logic [2:0] {
    MANUAL,
    CLEAR,
    FADE_UP,
    HOLD,
    FADE_DOWN,
    NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic          tick;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic [2:0]    step_q, step_d;
  logic [2:0]    mask;
  logic          skip_req;

  function automatic logic [2:0] inc_sat(input logic [2:0] l);
    return (l == 3'd7) ? 3'd7 : l + 3'd1;
  endfunction

  function automatic logic [2:0] dec_sat(input logic [2:0] l);
    return (l == 3'd0) ? 3'd0 : l - 3'd1;
  endfunction

`ifdef MOOD_SKIP_EN
  assign skip_req = pb_up;
`else
  assign skip_req = 1'b0;
`endif

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge main_Clk50Mhz or negedge main_rst) begin
    if (!main_rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_ff @(posedge main_Clk50Mhz or negedge main_rst) begin
    if (!main_rst) begin
      state_q <= MANUAL;
      hold_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      step_q  <= step_d;
    end
  end

  // Colour mask is index+1 so that index 0..6 walks R,G,RG,B,RB,GB,RGB.
  assign mask = step_q + 3'd1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    step_d  = step_q;

    if (state_q != MANUAL && !mode_auto) begin
      state_d = MANUAL;
      hold_d  = '0;
    end else begin
      case (state_q)
        MANUAL: begin
          if (mode_auto) begin
            state_d = CLEAR;
          end else if (pb_up && !pb_down) begin
            if (sw_rgb[0]) r_d = inc_sat(r_q);
            if (sw_rgb[1]) g_d = inc_sat(g_q);
            if (sw_rgb[2]) b_d = inc_sat(b_q);
          end else if (pb_down && !pb_up) begin
            if (sw_rgb[0]) r_d = dec_sat(r_q);
            if (sw_rgb[1]) g_d = dec_sat(g_q);
            if (sw_rgb[2]) b_d = dec_sat(b_q);
          end
        end

        CLEAR: begin
          if (tick) begin
            r_d = dec_sat(r_q);
            g_d = dec_sat(g_q);
            b_d = dec_sat(b_q);
            if ({r_d, g_d, b_d} == '0) state_d = FADE_UP;
          end
        end

        FADE_UP: begin
          if (skip_req) begin
            state_d = FADE_DOWN;
          end else if (tick) begin
            r_d = mask[0] ? inc_sat(r_q) : 3'd0;
            g_d = mask[1] ? inc_sat(g_q) : 3'd0;
            b_d = mask[2] ? inc_sat(b_q) : 3'd0;
            if ((!mask[0] || r_d == 3'd7) && (!mask[1] || g_d == 3'd7) &&
                (!mask[2] || b_d == 3'd7)) begin
              state_d = HOLD;
              hold_d  = '0;
            end
          end
        end

        HOLD: begin
          if (skip_req) begin
            state_d = FADE_DOWN;
            hold_d  = '0;
          end else if (tick) begin
            if (hold_q >= HOLD_END) begin
              state_d = FADE_DOWN;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end

        FADE_DOWN: begin
          if (tick) begin
            r_d = dec_sat(r_q);
            g_d = dec_sat(g_q);
            b_d = dec_sat(b_q);
            if ({r_d, g_d, b_d} == '0) state_d = NEXT;
          end
        end

        NEXT: begin
          step_d  = (step_q == 3'd6) ? 3'd0 : step_q + 3'd1;
          state_d = FADE_UP;
        end

        default: begin
          state_d = MANUAL;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign sel_r    = r_q;
  assign sel_g    = g_q;
  assign sel_b    = b_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_mood_fade_sequencer.sv
// Scoreboard bench for mood_fade_sequencer (TICK_DIV=4, HOLD_TICKS=2); honours `MOOD_SKIP_EN.
module tb_mood_fade_sequencer;

  localparam int TD = 4;
  localparam int HT = 2;
`ifdef MOOD_SKIP_EN
  localparam int SKIP_GAP = TD;
`else
  localparam int SKIP_GAP = TD * (HT + 1);
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_auto = 1'b0;
  logic       pb_up = 1'b0;
  logic       pb_down = 1'b0;
  logic [2:0] sw_rgb = '0;
  logic [2:0] sel_r, sel_g, sel_b, step_idx;

  int checks = 0;
  int errors = 0;
  int mr = 0, mg = 0, mb = 0;

  typedef struct {
    logic [11:0] t;
    int          gap;
  } exp_t;
  exp_t sb_q[$];

  mood_fade_sequencer #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .main_Clk50Mhz(clk),
    .main_rst     (rst_n),
    .mode_auto    (mode_auto),
    .pb_up        (pb_up),
    .pb_down      (pb_down),
    .sw_rgb       (sw_rgb),
    .sel_r        (sel_r),
    .sel_g        (sel_g),
    .sel_b        (sel_b),
    .step_idx     (step_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] obs();
    return {step_idx, sel_b, sel_g, sel_r};
  endfunction

  function automatic logic [11:0] mk(input int idx, input int r, input int g, input int b);
    return {3'(idx), 3'(b), 3'(g), 3'(r)};
  endfunction

  function automatic int clamp7(input int v);
    return (v > 7) ? 7 : (v < 0) ? 0 : v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] t, input int gap);
    exp_t e;
    e.t   = t;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  // One full colour: ramp masked channels 1..7, hold, ramp back to 0.
  task automatic push_color(input int idx, input int first_gap);
    int m;
    m = idx + 1;
    for (int k = 1; k <= 7; k++)
      push(mk(idx, m[0] ? k : 0, m[1] ? k : 0, m[2] ? k : 0), (k == 1) ? first_gap : TD);
    for (int k = 6; k >= 0; k--)
      push(mk(idx, m[0] ? k : 0, m[1] ? k : 0, m[2] ? k : 0), (k == 6) ? TD * (HT + 1) : TD);
  endtask

  task automatic press(input logic up, input logic dn);
    int   d;
    exp_t e;
    d = (up && !dn) ? 1 : (dn && !up) ? -1 : 0;
    if (sw_rgb[0]) mr = clamp7(mr + d);
    if (sw_rgb[1]) mg = clamp7(mg + d);
    if (sw_rgb[2]) mb = clamp7(mb + d);
    push(mk(int'(step_idx), mr, mg, mb), 0);
    pb_up   = up;
    pb_down = dn;
    cyc();
    pb_up   = 1'b0;
    pb_down = 1'b0;
    e = sb_q.pop_front();
    check("manual", 32'(obs()), 32'(e.t));
    cyc();
  endtask

  // Pops one expected entry per observed output change; gap is cycles since the previous change.
  task automatic run_sb(input int budget, input int down_at);
    logic [11:0] prev;
    int          last;
    exp_t        e;
    prev = obs();
    last = 0;
    for (int c = 1; c <= budget && sb_q.size() > 0; c++) begin
      pb_down = (c == down_at);
      cyc();
      if (obs() != prev) begin
        e = sb_q.pop_front();
        check("seq", 32'(obs()), 32'(e.t));
        if (e.gap != 0) check("gap", 32'(c - last), 32'(e.gap));
        last = c;
        prev = obs();
      end
    end
    pb_down = 1'b0;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    check("rst_async", 32'(obs()), 32'd0);
    mr = 0; mg = 0; mb = 0;
    cyc();
  endtask

  initial begin
    int n;
    #12;
    check("rst_out", 32'(obs()), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Manual saturation and simultaneous presses
    sw_rgb = 3'b001;
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) press(1'b0, 1'b1);
    sw_rgb = 3'b010;
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    sw_rgb = 3'b111;
    press(1'b1, 1'b0);
    sw_rgb = 3'b110;
    press(1'b0, 1'b1);
    check("manual_g3", 32'(sel_g), 32'd3);

    // Full automatic cycle through all seven colours and the wrap
    async_reset();
    mode_auto = 1'b1;
    rst_n     = 1'b1;
    for (int idx = 0; idx < 7; idx++) begin
      push_color(idx, (idx == 0) ? 0 : TD - 1);
      push(mk((idx + 1) % 7, 0, 0, 0), 1);
    end
    push(mk(0, 1, 0, 0), TD - 1);
    run_sb(1500, 30);

    // Reset mid-fade, then freeze at sel_r=4 and resume
    check("pre_rst_nonzero", 32'(obs() != 12'd0), 32'd1);
    async_reset();
    rst_n = 1'b1;
    n = 0;
    while (sel_r != 3'd4 && n < 200) begin
      cyc();
      n++;
    end
    check("wait_r4", 32'(sel_r), 32'd4);
    mode_auto = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    check("frozen", 32'(obs()), 32'(mk(0, 4, 0, 0)));
    sw_rgb = 3'b001;
    mr = 4; mg = 0; mb = 0;
    press(1'b1, 1'b0);
    mode_auto = 1'b1;
    for (int k = 4; k >= 0; k--) push(mk(0, k, 0, 0), (k == 4) ? 0 : TD);
    for (int k = 1; k <= 7; k++) push(mk(0, k, 0, 0), TD);
    run_sb(300, 0);

    // pb_up right after reaching full level: skip or full hold
    pb_up = 1'b1;
    cyc();
    pb_up = 1'b0;
    n = 1;
    while (sel_r == 3'd7 && n < 40) begin
      cyc();
      n++;
    end
    check("skip_gap", 32'(n), 32'(SKIP_GAP));
    check("skip_r6", 32'(obs()), 32'(mk(0, 6, 0, 0)));
    for (int k = 5; k >= 0; k--) push(mk(0, k, 0, 0), TD);
    push(mk(1, 0, 0, 0), 1);
    push(mk(1, 0, 1, 0), TD - 1);
    push(mk(1, 0, 2, 0), TD);
    run_sb(200, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
